// File: rtl/rdma_rc_pkg.sv
// Definitions shared by the RC PDU parser and builder: QP states, opcode classes, and PDU field offsets.
package rdma_rc_pkg;

    typedef enum logic [2:0] {
        QP_RESET = 3'b000,
        QP_INIT  = 3'b001,
        QP_RTR   = 3'b010,
        QP_RTS   = 3'b011,
        QP_ERROR = 3'b111
    } qp_state_e;

    typedef enum logic [1:0] {
        PDU_DATA = 2'd0,
        PDU_CTRL = 2'd1,
        PDU_RSVD = 2'd2
    } pdu_class_e;

    localparam logic [7:0] DATA_MAX = 8'h1F;
    localparam logic [7:0] CTRL_MAX = 8'h7F;

    localparam int OPCODE_OFFSET = 56;
    localparam int QPN_OFFSET    = 32;
    localparam int PSN_OFFSET    = 8;

endpackage

// File: rtl/rdma_rc_opcode_check.sv
// Combinational opcode classification and QP-state legality check, shared by the parser and builder.
module rdma_rc_opcode_check
    import rdma_rc_pkg::*;
#(
    parameter int OPCODE_WIDTH = 8
) (
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [2:0]              qp_state,
    output logic                    is_data,
    output logic                    legal
);

    pdu_class_e op_class;

    // NOTE: every output of a combinational block is given a default first so no path can infer a latch.
    always_comb begin
        op_class = PDU_RSVD;
        if (opcode <= OPCODE_WIDTH'(DATA_MAX)) begin
            op_class = PDU_DATA;
        end else if (opcode <= OPCODE_WIDTH'(CTRL_MAX)) begin
            op_class = PDU_CTRL;
        end

        legal = 1'b0;
        case (qp_state_e'(qp_state))
            QP_RTS:  legal = (op_class == PDU_DATA);
            QP_RTR:  legal = (op_class == PDU_CTRL);
            default: legal = 1'b0;
        endcase

        is_data = (op_class == PDU_DATA);
    end

endmodule

// File: rtl/rdma_rc_pdu_builder.sv
// RC transmit PDU builder: validates send requests, owns the send PSN, presents PDUs on valid/ready.
// Optional statistics counters are enabled with the macro RDMA_PDU_TX_STATS_EN.
module rdma_rc_pdu_builder
    import rdma_rc_pkg::*;
#(
    parameter int QPN_WIDTH    = 16,
    parameter int PSN_WIDTH    = 24,
    parameter int OPCODE_WIDTH = 8,
    parameter int DATA_WIDTH   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              qp_state,
    input  logic [QPN_WIDTH-1:0]    remote_qpn,
    input  logic                    psn_load,
    input  logic [PSN_WIDTH-1:0]    psn_init,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [OPCODE_WIDTH-1:0] req_opcode,
    output logic [DATA_WIDTH-1:0]   pdu_data,
    output logic                    pdu_valid,
    input  logic                    pdu_ready,
    output logic [PSN_WIDTH-1:0]    cur_psn,
    output logic                    req_reject,
    output logic                    flush_err
`ifdef RDMA_PDU_TX_STATS_EN
    ,
    output logic [31:0]             tx_data_cnt,
    output logic [31:0]             tx_ctrl_cnt,
    output logic [31:0]             tx_reject_cnt
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic                    alive_q;
    logic                    pend_data_q;
    logic [DATA_WIDTH-1:0]   pdu_q;
    logic [PSN_WIDTH-1:0]    psn_q;
    logic                    reject_q, flush_q;
    logic                    req_is_data, req_legal;
    logic                    qp_err;
    logic                    do_latch, do_reject, do_flush, data_hs, ctrl_hs;
    logic [DATA_WIDTH-1:0]   pdu_word;

    rdma_rc_opcode_check #(
        .OPCODE_WIDTH(OPCODE_WIDTH)
    ) u_opcode_check (
        .opcode  (req_opcode),
        .qp_state(qp_state),
        .is_data (req_is_data),
        .legal   (req_legal)
    );

    assign qp_err    = (qp_state == QP_ERROR);
    // alive_q keeps req_ready low while reset is asserted, without a combinational reset path.
    assign req_ready = alive_q && (state_q == S_IDLE) && !qp_err;
    assign pdu_valid = (state_q == S_SEND);
    assign pdu_data  = pdu_q;
    assign cur_psn   = psn_q;
    assign req_reject = reject_q;
    assign flush_err  = flush_q;

    always_comb begin
        pdu_word = '0;
        pdu_word[OPCODE_OFFSET +: OPCODE_WIDTH] = req_opcode;
        pdu_word[QPN_OFFSET +: QPN_WIDTH]       = remote_qpn;
        pdu_word[PSN_OFFSET +: PSN_WIDTH]       = psn_q;
    end

    always_comb begin
        state_d   = state_q;
        do_latch  = 1'b0;
        do_reject = 1'b0;
        do_flush  = 1'b0;
        data_hs   = 1'b0;
        ctrl_hs   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    if (req_legal) begin
                        state_d  = S_SEND;
                        do_latch = 1'b1;
                    end else begin
                        do_reject = 1'b1;
                    end
                end
            end
            S_SEND: begin
                // A handshake wins over ERROR in the same cycle.
                if (pdu_ready) begin
                    state_d = S_IDLE;
                    data_hs = pend_data_q;
                    ctrl_hs = !pend_data_q;
                end else if (qp_err) begin
                    state_d  = S_IDLE;
                    do_flush = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            alive_q     <= 1'b0;
            pend_data_q <= 1'b0;
            pdu_q       <= '0;
            psn_q       <= '0;
            reject_q    <= 1'b0;
            flush_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            alive_q  <= 1'b1;
            reject_q <= do_reject;
            flush_q  <= do_flush;
            if (do_latch) begin
                pdu_q       <= pdu_word;
                pend_data_q <= req_is_data;
            end
            if (psn_load) begin
                psn_q <= psn_init;
            end else if (data_hs) begin
                psn_q <= psn_q + PSN_WIDTH'(1);
            end
        end
    end

`ifdef RDMA_PDU_TX_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_cnt   <= '0;
            tx_ctrl_cnt   <= '0;
            tx_reject_cnt <= '0;
        end else begin
            if (data_hs && (tx_data_cnt != '1)) begin
                tx_data_cnt <= tx_data_cnt + 32'd1;
            end
            if (ctrl_hs && (tx_ctrl_cnt != '1)) begin
                tx_ctrl_cnt <= tx_ctrl_cnt + 32'd1;
            end
            if ((reject_q || flush_q) && (tx_reject_cnt != '1)) begin
                tx_reject_cnt <= tx_reject_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rdma_rc_pdu_builder.sv
// Self-checking bench for rdma_rc_pdu_builder: directed cases plus randomized requests, scoreboard-checked.
module tb_rdma_rc_pdu_builder;

    localparam logic [2:0] ST_RESET = 3'b000;
    localparam logic [2:0] ST_INIT  = 3'b001;
    localparam logic [2:0] ST_RTR   = 3'b010;
    localparam logic [2:0] ST_RTS   = 3'b011;
    localparam logic [2:0] ST_ERROR = 3'b111;

    localparam int K_PDU   = 0;
    localparam int K_REJ   = 1;
    localparam int K_FLUSH = 2;

    localparam int M_NORMAL = 0;
    localparam int M_FLUSH  = 1;
    localparam int M_LOST   = 2;

    typedef struct {
        int          kind;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  qp_state;
    logic [15:0] remote_qpn;
    logic        psn_load;
    logic [23:0] psn_init;
    logic        req_valid;
    logic        req_ready;
    logic [7:0]  req_opcode;
    logic [63:0] pdu_data;
    logic        pdu_valid;
    logic        pdu_ready;
    logic [23:0] cur_psn;
    logic        req_reject;
    logic        flush_err;
`ifdef RDMA_PDU_TX_STATS_EN
    logic [31:0] tx_data_cnt, tx_ctrl_cnt, tx_reject_cnt;
`endif

    exp_t        exp_q[$];
    logic [23:0] model_psn;
    int          n_tests = 0;
    int          n_fail  = 0;
    bit          rand_ready_en = 1'b0;
    bit          prev_stall = 1'b0;
    logic [63:0] prev_data;

    always #5 clk = ~clk;

    rdma_rc_pdu_builder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .qp_state  (qp_state),
        .remote_qpn(remote_qpn),
        .psn_load  (psn_load),
        .psn_init  (psn_init),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opcode(req_opcode),
        .pdu_data  (pdu_data),
        .pdu_valid (pdu_valid),
        .pdu_ready (pdu_ready),
        .cur_psn   (cur_psn),
        .req_reject(req_reject),
        .flush_err (flush_err)
`ifdef RDMA_PDU_TX_STATS_EN
        ,
        .tx_data_cnt  (tx_data_cnt),
        .tx_ctrl_cnt  (tx_ctrl_cnt),
        .tx_reject_cnt(tx_reject_cnt)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference rules: data 00-1F only in RTS, control 20-7F only in RTR, 80-FF never.
    function automatic bit ref_legal(input logic [7:0] op, input logic [2:0] qs);
        if (op >= 8'h80) return 1'b0;
        if (qs == ST_RTS) return (op < 8'h20);
        if (qs == ST_RTR) return (op >= 8'h20);
        return 1'b0;
    endfunction

    task automatic expect_event(input int kind, input logic [63:0] data);
        exp_t e;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got unexpected kind=%0d data=%h, expected nothing (t=%0t)", kind, data, $time);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == K_PDU && e.data !== data)) begin
                n_fail++;
                $display("FAIL event: got kind=%0d data=%h, expected kind=%0d data=%h (t=%0t)",
                         kind, data, e.kind, e.data, $time);
            end
        end
    endtask

    // Monitor: observes outputs on the falling edge and checks them against the scoreboard.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {63'd0, pdu_valid}, 64'd1);
                check("hold_data", pdu_data, prev_data);
            end
            if (req_reject) expect_event(K_REJ, 64'd0);
            if (flush_err)  expect_event(K_FLUSH, 64'd0);
            if (pdu_valid && pdu_ready) expect_event(K_PDU, pdu_data);
            prev_stall = pdu_valid && !pdu_ready && (qp_state != ST_ERROR);
            prev_data  = pdu_data;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_ready_en) pdu_ready = ($urandom_range(0, 2) != 0);
        end
    end

    task automatic issue(input logic [7:0] op, input logic [2:0] qs, input logic [15:0] qpn, input int mode);
        bit   lg;
        int   n;
        exp_t e;
        @(posedge clk);
        #1;
        qp_state   = qs;
        remote_qpn = qpn;
        req_opcode = op;
        req_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("ready_timeout", {63'd0, req_ready}, 64'd1);
            req_valid = 1'b0;
            return;
        end
        check("idle_psn", {40'd0, cur_psn}, {40'd0, model_psn});
        lg = ref_legal(op, qs);
        if (!lg) begin
            e.kind = K_REJ; e.data = '0; exp_q.push_back(e);
        end else if (mode == M_NORMAL) begin
            e.kind = K_PDU; e.data = {op, 8'h00, qpn, model_psn, 8'h00}; exp_q.push_back(e);
            if (op < 8'h20) model_psn = model_psn + 24'd1;
        end else if (mode == M_FLUSH) begin
            e.kind = K_FLUSH; e.data = '0; exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("valid_after_accept", {63'd0, pdu_valid}, {63'd0, lg});
    endtask

    task automatic load_psn(input logic [23:0] v);
        @(posedge clk);
        #1;
        psn_load = 1'b1;
        psn_init = v;
        @(posedge clk);
        #1;
        psn_load = 1'b0;
        model_psn = v;
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"},  {63'd0, pdu_valid},  64'd0);
        check({tag, "_ready"},  {63'd0, req_ready},  64'd0);
        check({tag, "_reject"}, {63'd0, req_reject}, 64'd0);
        check({tag, "_flush"},  {63'd0, flush_err},  64'd0);
        check({tag, "_psn"},    {40'd0, cur_psn},    64'd0);
        check({tag, "_data"},   pdu_data,            64'd0);
    endtask

    initial begin
        logic [23:0] held_psn;
        logic [7:0]  op;
        logic [2:0]  qs;
        int          n;

        rst_n = 1'b0; qp_state = ST_RESET; remote_qpn = '0; psn_load = 1'b0; psn_init = '0;
        req_valid = 1'b0; req_opcode = '0; pdu_ready = 1'b1; model_psn = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic data frame and PSN advance.
        load_psn(24'h000001);
        issue(8'h05, ST_RTS, 16'h5678, M_NORMAL);
        @(negedge clk);
        check("psn_after_data", {40'd0, cur_psn}, 64'h2);

        // Control frame in RTR keeps the PSN; data in RTR is refused.
        issue(8'h25, ST_RTR, 16'h1234, M_NORMAL);
        issue(8'h05, ST_RTR, 16'h1234, M_NORMAL);
        issue(8'h25, ST_RTS, 16'h1234, M_NORMAL);
        issue(8'h11, ST_INIT, 16'h1234, M_NORMAL);
        issue(8'h85, ST_RTS, 16'h1234, M_NORMAL);
        issue(8'h00, ST_RESET, 16'h1234, M_NORMAL);
        @(negedge clk);
        check("psn_after_rejects", {40'd0, cur_psn}, 64'h2);

        // Back-pressure: PDU held for five cycles, PSN moves only on the handshake.
        pdu_ready = 1'b0;
        issue(8'h1F, ST_RTS, 16'hABCD, M_NORMAL);
        held_psn = cur_psn;
        repeat (4) begin
            @(negedge clk);
            check("stall_psn", {40'd0, cur_psn}, 64'h2);
        end
        @(posedge clk);
        #1;
        pdu_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("psn_after_stall", {40'd0, cur_psn}, 64'h3);

        // psn_load during SEND: in-flight PDU keeps its PSN, increment applies to the loaded value.
        pdu_ready = 1'b0;
        issue(8'h07, ST_RTS, 16'h0F0F, M_NORMAL);
        load_psn(24'h000100);
        model_psn = 24'h000101;
        @(posedge clk);
        #1;
        pdu_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("psn_after_midload", {40'd0, cur_psn}, 64'h101);

        // PSN wrap.
        load_psn(24'hFFFFFF);
        issue(8'h02, ST_RTS, 16'h0001, M_NORMAL);
        issue(8'h03, ST_RTS, 16'h0002, M_NORMAL);
        @(negedge clk);
        @(negedge clk);
        check("psn_wrap", {40'd0, cur_psn}, 64'h1);

        // ERROR while stalled: PDU flushed, PSN untouched.
        pdu_ready = 1'b0;
        issue(8'h04, ST_RTS, 16'h4444, M_FLUSH);
        @(posedge clk);
        #1;
        qp_state = ST_ERROR;
        @(negedge clk);
        @(negedge clk);
        check("flush_pulse", {63'd0, flush_err}, 64'd1);
        check("flush_valid", {63'd0, pdu_valid}, 64'd0);
        check("flush_ready", {63'd0, req_ready}, 64'd0);
        check("flush_psn", {40'd0, cur_psn}, 64'h1);
        @(posedge clk);
        #1;
        qp_state = ST_RTS;
        pdu_ready = 1'b1;

        // ERROR coincident with handshake: PDU completes, no flush.
        pdu_ready = 1'b0;
        issue(8'h06, ST_RTS, 16'h6666, M_NORMAL);
        @(posedge clk);
        #1;
        qp_state  = ST_ERROR;
        pdu_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("err_hs_psn", {40'd0, cur_psn}, 64'h2);
        @(posedge clk);
        #1;
        qp_state = ST_RTS;

        // Asynchronous reset in the middle of SEND.
        pdu_ready = 1'b0;
        issue(8'h08, ST_RTS, 16'h8888, M_LOST);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("async_rst");
        model_psn = '0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pdu_ready = 1'b1;

        // Randomized requests with random back-pressure.
        rand_ready_en = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 15) == 0) load_psn(24'($urandom));
            case ($urandom_range(0, 5))
                0:       qs = ST_INIT;
                1:       qs = ST_RESET;
                2, 3:    qs = ST_RTR;
                default: qs = ST_RTS;
            endcase
            case ($urandom_range(0, 3))
                0:       op = 8'($urandom_range(8'h20, 8'h7F));
                1:       op = 8'($urandom_range(8'h80, 8'hFF));
                default: op = 8'($urandom_range(8'h00, 8'h1F));
            endcase
            issue(op, qs, 16'($urandom), M_NORMAL);
        end

        @(posedge clk);
        #1;
        rand_ready_en = 1'b0;
        pdu_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        check("final_psn", {40'd0, cur_psn}, {40'd0, model_psn});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rdma_rc_pdu_builder.md
Name: rdma_rc_pdu_builder

Overview:
- Transmit-side counterpart of the RC PDU parser.
- Accepts opcode send requests from the QP engine and checks each against QP state and opcode class.
- Builds the 64-bit PDU word using the same field layout the parser decodes: opcode, destination QPN, PSN.
- Owns the send-PSN counter and presents PDUs on a valid/ready interface toward the link/MAC side.

Parameters:
- QPN_WIDTH, 16, QPN field width
- PSN_WIDTH, 24, PSN field and counter width
- OPCODE_WIDTH, 8, opcode field width
- DATA_WIDTH, 64, PDU word width

Ports:
- clk  in  1  single clock
- rst_n  in  1  asynchronous active-low reset
- qp_state  in  3  RESET=000, INIT=001, RTR=010, RTS=011, ERROR=111
- remote_qpn  in  QPN_WIDTH  destination QPN inserted in every PDU
- psn_load  in  1  one-cycle strobe: load send PSN
- psn_init  in  PSN_WIDTH  value loaded on psn_load
- req_valid  in  1  send request valid
- req_ready  out  1  builder can accept a request
- req_opcode  in  OPCODE_WIDTH  requested opcode
- pdu_data  out  DATA_WIDTH  built PDU word
- pdu_valid  out  1  PDU valid
- pdu_ready  in  1  downstream accepts PDU
- cur_psn  out  PSN_WIDTH  next PSN to be sent
- req_reject  out  1  one-cycle pulse: request refused
- flush_err  out  1  one-cycle pulse: pending PDU dropped on ERROR

Behaviour:
- Reset: all outputs 0; FSM to IDLE; PSN counter 0.
- PDU layout:
  - [63:56] opcode
  - [55:48] zero
  - [47:32] remote_qpn, sampled at accept
  - [31:8] PSN
  - [7:0] zero
- Opcode classes:
  - data: 0x00–0x1F
  - control: 0x20–0x7F
  - reserved: 0x80–0xFF
- Legality:
  - data frames only in RTS
  - control frames only in RTR
  - reserved opcodes always illegal
  - RESET, INIT and ERROR permit nothing
- FSM states: IDLE, SEND.
  - req_ready = (state==IDLE) && qp_state!=ERROR.
- IDLE, accept cycle N (req_valid && req_ready):
  - Legal request: latch the PDU word, go to SEND; pdu_valid=1 from cycle N+1.
  - Illegal request: req_reject=1 at cycle N+1, stay IDLE, PSN unchanged, no PDU.
- SEND:
  - pdu_data and pdu_valid hold stable until pdu_ready. No valid drop, no data change.
  - On handshake (pdu_valid && pdu_ready): return to IDLE. Next request is accepted no earlier than the following cycle (one bubble; throughput 1 PDU per 2 cycles).
  - Data frame handshake: PSN += 1, mod 2^PSN_WIDTH (0xFFFFFF wraps to 0x000000).
  - Control frame handshake: carries the current PSN; PSN not incremented.
- qp_state==ERROR while in SEND (and no handshake that cycle):
  - pdu_valid drops next cycle.
  - flush_err pulses 1 cycle.
  - Return to IDLE; PSN unchanged.
- ERROR coincident with a handshake: the handshake completes normally; no flush.
- psn_load:
  - Honoured in any state; overrides a same-cycle increment.
  - Does not alter the PSN already latched in an in-flight PDU.
- cur_psn always reflects the counter register.
- Asynchronous reset mid-SEND: the PDU is lost and all outputs return to 0 immediately.

Optional Feature:
- Macro RDMA_PDU_TX_STATS_EN.
- When defined, three extra outputs are added, each a 32-bit saturating counter cleared on reset:
  - tx_data_cnt: increments on data-frame handshake
  - tx_ctrl_cnt: increments on control-frame handshake
  - tx_reject_cnt: increments on req_reject or flush_err pulse
- When undefined, the ports and counters are absent and core behaviour is identical.

Decomposition:
- Shared package rdma_rc_pkg (shared with the parser) holds:
  - qp_state_e enum
  - opcode class bounds (DATA_MAX=0x1F, CTRL_MAX=0x7F)
  - field offsets (OPCODE_OFFSET=56, QPN_OFFSET=32, PSN_OFFSET=8)
  - the pdu_class_e typedef
- One sub-module: rdma_rc_opcode_check. Combinational classify + legality from opcode and qp_state; reusable by the parser.

Test Plan:
- RTS, psn_load 0x000001, data opcode 0x05, remote_qpn 0x5678, pdu_ready=1 → pdu_data=0x0500_5678_0000_0100, pdu_valid one cycle after accept, cur_psn becomes 0x000002.
- RTR, control 0x25 → PDU sent with the current PSN, cur_psn unchanged. Then RTR + data 0x05 → req_reject pulse, no pdu_valid.
- RTS + control 0x25, INIT + any opcode, and RTS + reserved 0x85 → each gives req_reject and no PDU.
- RTS data, pdu_ready held low 5 cycles → pdu_valid and pdu_data stable for all 5 cycles; PSN increments only on the cycle pdu_ready rises.
- psn_load 0xFFFFFF, two RTS data PDUs → PSNs 0xFFFFFF then 0x000000; cur_psn ends at 0x000001.
- In SEND with pdu_ready=0, qp_state→ERROR → flush_err pulse, pdu_valid low next cycle, req_ready stays 0, PSN unchanged. Also: rst_n low mid-SEND → all outputs 0 asynchronously.
